pll_freq_lock_mon: RTL and testbench
====================================

// Module: pll_freq_lock_mon
// PURPOSE
//  Consumer-side checker for the rPLL output. Counts rising edges of a divided PLL clock
//  (e.g. CLKOUTD), sampled as data in the clk domain, over a fixed gate window.
//  Qualifies the measured frequency plus the PLL LOCK pin into a debounced locked flag
//  that gates the SPI SRAM demo logic. Reports loss-of-lock events.
// PARAMETERS
//  GATE_CYCLES   27000  clk cycles per measurement window (1 ms at 27 MHz); >= 4
//  CNT_W         16     width of the edge counter and count_o
//  EXP_COUNT     3375   expected edges per window
//  TOL           8      allowed |count - EXP_COUNT| for a window to pass
//  LOCK_WINDOWS  4      consecutive passing windows required to assert locked
// PORTS
//  clk           in   1      system clock; single clock domain
//  rst           in   1      synchronous, active-high reset
//  en            in   1      monitor enable; low = idle and clear
//  meas_in       in   1      async divided PLL clock; freq must be < clk/2
//  pll_lock      in   1      async rPLL LOCK pin
//  count_o       out  CNT_W  edge count of the last completed window
//  count_valid   out  1      1-cycle pulse: count_o/in_tol updated
//  in_tol        out  1      last completed window passed tolerance
//  overflow      out  1      last completed window saturated the edge counter
//  locked        out  1      debounced frequency lock
//  lost_lock     out  1      1-cycle pulse on LOCKED -> LOST transition
//  lost_sticky   out  1      set by lost_lock; cleared only by rst or en=0
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Synchronizers also cleared.
//  - meas_in and pll_lock each pass a 2-FF synchronizer. A rising edge is a 0->1 of the
//    synced meas_in; the edge pulse trails the meas_in pin edge by 3 clk.
//  - Gate counter runs 0..GATE_CYCLES-1 while en=1 and wraps. An edge in the last gate
//    cycle counts toward the closing window. The edge counter saturates at 2^CNT_W-1.
//    Saturation sets overflow for that window.
//  - Window end, the cycle after the gate counter is GATE_CYCLES-1:
//    - count_o is updated.
//    - count_valid pulses.
//    - in_tol is computed in CNT_W+1 bits: |count - EXP_COUNT| <= TOL and !overflow.
//    - edge counter restarts at 0.
//  - State machine (evaluated on count_valid unless noted):
//    - IDLE: en=1 -> ACQUIRE. Gate and pass counters start from 0.
//    - ACQUIRE:
//      - window passes and synced pll_lock=1 -> pass_cnt++;
//      - otherwise pass_cnt=0;
//      - pass_cnt reaching LOCK_WINDOWS -> LOCKED, locked=1 next cycle.
//    - LOCKED: any failing window, or synced pll_lock=0 on any cycle (not only at window
//      end) -> LOST. locked drops, lost_lock pulses and lost_sticky sets, all in the same
//      cycle as the transition register update.
//    - LOST: at the next window end -> ACQUIRE with pass_cnt=0, regardless of that
//      window's result.
//  - en=0 in any state, next cycle:
//    - state IDLE; gate, edge and pass counters cleared;
//    - locked, in_tol, overflow, lost_sticky cleared; count_o held.
//  - rst mid-window: the partial window is discarded, no count_valid.
//  - Simultaneous pll_lock drop and passing window end while LOCKED: LOST wins.
// TESTING (GATE_CYCLES=100, EXP_COUNT=25, TOL=1, LOCK_WINDOWS=3, CNT_W=8)
//  1. meas_in period 4 clk, pll_lock=1, en=1 -> count_valid every 100 clk.
//     count_o=25 from window 2 (window 1 may read 24). locked=1 after 3 passing windows.
//  2. Locked. Switch meas_in to period 5 -> count_o=20, in_tol=0.
//     locked=0, lost_lock one pulse, lost_sticky=1. ACQUIRE one window later.
//  3. Locked. Pull pll_lock low mid-window -> locked falls 3 clk after the pin
//     (2 sync + 1), not at window end.
//  4. CNT_W=4 variant, meas_in period 2 -> count_o=15, overflow=1, in_tol=0.
//     Never locks.
//  5. Passing, fail, passing, passing, passing -> locked asserts only after the third
//     consecutive pass.
//  6. en=0 for 1 cycle while LOCKED -> locked, lost_sticky clear, no lost_lock pulse.
//     Relock after 3 windows.

Source files
------------

// File: rtl/pll_freq_lock_mon.sv
// PLL frequency/lock monitor: counts synced edges of a divided PLL clock per gate window
// and turns passing windows plus the PLL LOCK pin into a debounced locked flag.
//
// state   | meaning
// IDLE    | monitor disabled, counters cleared
// ACQUIRE | counting consecutive passing windows toward lock
// LOCKED  | frequency and LOCK pin qualified
// LOST    | lock dropped; waiting one window end before re-acquiring
module pll_freq_lock_mon #(
    parameter int GATE_CYCLES  = 27000,
    parameter int CNT_W        = 16,
    parameter int EXP_COUNT    = 3375,
    parameter int TOL          = 8,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             meas_in,
    input  logic             pll_lock,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid,
    output logic             in_tol,
    output logic             overflow,
    output logic             locked,
    output logic             lost_lock,
    output logic             lost_sticky
);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int PASS_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    EXP_EXT   = (CNT_W+1)'(EXP_COUNT);
    localparam logic [CNT_W:0]    TOL_EXT   = (CNT_W+1)'(TOL);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(LOCK_WINDOWS - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

    state_t              state, state_nxt;
    logic [PASS_W-1:0]   pass_cnt, pass_nxt;
    logic                lost_evt;
    logic                meas_s1, meas_s2, meas_s3;
    logic                lock_s1, lock_s2;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt, edge_nxt;
    logic                ovf_win, ovf_nxt;
    logic                edge_p, edge_sat, gate_last, tol_ok;
    logic [CNT_W:0]      cnt_ext, diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_s1 <= 1'b0;
            meas_s2 <= 1'b0;
            meas_s3 <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            meas_s1 <= meas_in;
            meas_s2 <= meas_s1;
            meas_s3 <= meas_s2;
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
        end
    end

    // An edge arriving in the last gate cycle still belongs to the closing window.
    always_comb begin
        edge_p    = meas_s2 & ~meas_s3;
        gate_last = en && (gate_cnt == GATE_LAST);
        edge_sat  = edge_p && (edge_cnt == CNT_MAX);
        edge_nxt  = (edge_p && !edge_sat) ? edge_cnt + 1'b1 : edge_cnt;
        ovf_nxt   = ovf_win | edge_sat;
        cnt_ext   = {1'b0, edge_nxt};
        diff      = (cnt_ext >= EXP_EXT) ? cnt_ext - EXP_EXT : EXP_EXT - cnt_ext;
        tol_ok    = (diff <= TOL_EXT) && !ovf_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf_win     <= 1'b0;
            count_o     <= '0;
            count_valid <= 1'b0;
            in_tol      <= 1'b0;
            overflow    <= 1'b0;
        end else if (!en) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf_win     <= 1'b0;
            count_valid <= 1'b0;
            in_tol      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= gate_last;
            if (gate_last) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_win  <= 1'b0;
                count_o  <= edge_nxt;
                in_tol   <= tol_ok;
                overflow <= ovf_nxt;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_nxt;
                ovf_win  <= ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pass_cnt    <= '0;
            lost_lock   <= 1'b0;
            lost_sticky <= 1'b0;
        end else begin
            state       <= state_nxt;
            pass_cnt    <= pass_nxt;
            lost_lock   <= lost_evt;
            lost_sticky <= en && (lost_sticky || lost_evt);
        end
    end

    // A LOCK pin drop is acted on immediately while locked, not only at window end.
    always_comb begin
        state_nxt = state;
        pass_nxt  = pass_cnt;
        lost_evt  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            pass_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ACQUIRE;
                    pass_nxt  = '0;
                end
                ACQUIRE: begin
                    if (count_valid) begin
                        if (in_tol && lock_s2) begin
                            if (pass_cnt == PASS_LAST) begin
                                state_nxt = LOCKED;
                                pass_nxt  = '0;
                            end else begin
                                pass_nxt = pass_cnt + 1'b1;
                            end
                        end else begin
                            pass_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_s2 || (count_valid && !in_tol)) begin
                        state_nxt = LOST;
                        lost_evt  = 1'b1;
                    end
                end
                LOST: begin
                    if (count_valid) begin
                        state_nxt = ACQUIRE;
                        pass_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    pass_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end
endmodule

// File: tb/tb_pll_freq_lock_mon.sv
// Directed bench for pll_freq_lock_mon: a CNT_W=8 instance walks through lock, loss and
// re-enable scenarios while a CNT_W=4 instance runs a saturating input alongside.
module tb_pll_freq_lock_mon;
    logic       clk = 1'b0;
    logic       rst, en, en_b, pll_lock;
    logic       meas_a = 1'b0;
    logic       meas_b = 1'b0;
    logic [7:0] count_a;
    logic       cv_a, tol_a, ovf_a, locked_a, lost_a, sticky_a;
    logic [3:0] count_b;
    logic       cv_b, tol_b, ovf_b, locked_b, lost_b, sticky_b;

    int n_checks = 0;
    int n_err    = 0;
    int n_lost   = 0;
    int period   = 4;
    int phase    = 0;
    int cyc;

    always #5 clk = ~clk;

    pll_freq_lock_mon #(.GATE_CYCLES(100), .CNT_W(8), .EXP_COUNT(25), .TOL(1),
                        .LOCK_WINDOWS(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .meas_in(meas_a), .pll_lock(pll_lock),
        .count_o(count_a), .count_valid(cv_a), .in_tol(tol_a), .overflow(ovf_a),
        .locked(locked_a), .lost_lock(lost_a), .lost_sticky(sticky_a));

    pll_freq_lock_mon #(.GATE_CYCLES(100), .CNT_W(4), .EXP_COUNT(25), .TOL(1),
                        .LOCK_WINDOWS(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .meas_in(meas_b), .pll_lock(pll_lock),
        .count_o(count_b), .count_valid(cv_b), .in_tol(tol_b), .overflow(ovf_b),
        .locked(locked_b), .lost_lock(lost_b), .lost_sticky(sticky_b));

    // Divided-clock stand-ins: meas_a has a programmable period, meas_b toggles every cycle.
    initial begin
        forever begin
            @(negedge clk);
            phase  = (phase + 1 >= period) ? 0 : phase + 1;
            meas_a = (phase < period / 2);
            meas_b = ~meas_b;
        end
    end

    always @(negedge clk) if (lost_a) n_lost++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cv(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!cv_a && cycles < 400);
        check("cv_seen", cv_a, 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_b = 1'b0; pll_lock = 1'b1;
        repeat (3) tick();
        check("rst_count", count_a, 0);
        check("rst_flags", {cv_a, tol_a, ovf_a, locked_a, lost_a, sticky_a}, 0);
        check("rst_b_count", count_b, 0);

        // Scenario 1: nominal period 4, locks after three passing windows
        rst = 1'b0; en = 1'b1; en_b = 1'b1;
        wait_cv(cyc);
        check("w1_len", cyc, 100);
        check("w1_tol", tol_a, 1);
        check("w1_locked", locked_a, 0);
        check("b_cv", cv_b, 1);
        check("b_count", count_b, 15);
        check("b_ovf", ovf_b, 1);
        check("b_tol", tol_b, 0);
        wait_cv(cyc);
        check("w2_len", cyc, 100);
        check("w2_count", count_a, 25);
        check("w2_ovf", ovf_a, 0);
        check("w2_locked", locked_a, 0);
        wait_cv(cyc);
        check("w3_count", count_a, 25);
        check("w3_locked_at_cv", locked_a, 0);
        tick();
        check("w3_locked", locked_a, 1);

        // Scenario 2: frequency off -> LOST, then ACQUIRE one window later
        period = 5;
        wait_cv(cyc);
        check("bad_tol", tol_a, 0);
        check("bad_locked_at_cv", locked_a, 1);
        tick();
        check("bad_locked", locked_a, 0);
        check("bad_lost_pulse", lost_a, 1);
        check("bad_sticky", sticky_a, 1);
        tick();
        check("bad_lost_end", lost_a, 0);
        wait_cv(cyc);
        check("p5_count", count_a, 20);
        check("p5_tol", tol_a, 0);
        check("n_lost_1", n_lost, 1);

        // Scenario 5: pass, fail (LOCK pin low at window end), pass x3
        period = 4;
        wait_cv(cyc);
        wait_cv(cyc);
        check("acq_count", count_a, 25);
        tick();
        check("acq_w2_locked", locked_a, 0);
        repeat (88) tick();
        pll_lock = 1'b0;
        wait_cv(cyc);
        tick();
        check("acq_fail_locked", locked_a, 0);
        pll_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cv(cyc);
            tick();
            check("relock_seq", locked_a, (i == 2) ? 1 : 0);
        end
        check("sticky_held", sticky_a, 1);

        // Scenario 3: LOCK pin drops mid-window, locked falls 3 clk later
        repeat (40) tick();
        pll_lock = 1'b0;
        tick();
        check("pin_drop_1", locked_a, 1);
        tick();
        check("pin_drop_2", locked_a, 1);
        tick();
        check("pin_drop_3", locked_a, 0);
        check("pin_drop_lost", lost_a, 1);
        pll_lock = 1'b1;
        tick();
        check("n_lost_2", n_lost, 2);
        for (int i = 0; i < 4; i++) begin
            wait_cv(cyc);
            tick();
            check("relock_after_drop", locked_a, (i == 3) ? 1 : 0);
        end

        // Scenario 6: one cycle of en=0 while locked
        en = 1'b0;
        tick();
        check("dis_locked", locked_a, 0);
        check("dis_sticky", sticky_a, 0);
        check("dis_tol", tol_a, 0);
        check("dis_count_held", count_a, 25);
        en = 1'b1;
        wait_cv(cyc);
        check("reen_len", cyc, 100);
        tick();
        check("reen_w1_locked", locked_a, 0);
        wait_cv(cyc);
        tick();
        check("reen_w2_locked", locked_a, 0);
        wait_cv(cyc);
        tick();
        check("reen_w3_locked", locked_a, 1);
        check("n_lost_final", n_lost, 2);
        check("b_never_locked", {locked_b, sticky_b}, 0);
        check("b_ovf_final", ovf_b, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
